// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock.
// A start in IDLE or DONE latches the operands; N_BITS SHIFT cycles later the
// quotient/remainder registers load and done pulses for one cycle. A zero
// divisor skips SHIFT and reports all-ones quotient with the dividend as
// remainder, flagged by div_by_zero.
module divider #(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] dividend,
  input  logic [N_BITS-1:0] divisor,
  output logic [N_BITS-1:0] quotient,
  output logic [N_BITS-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int             CW        = $clog2(N_BITS + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(N_BITS - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [N_BITS-1:0] prem_q,  prem_d;   // partial remainder (always < divisor)
  logic [N_BITS-1:0] work_q,  work_d;   // dividend shifting out, quotient shifting in
  logic [N_BITS-1:0] dsr_q,   dsr_d;    // latched divisor
  logic [N_BITS-1:0] quot_q,  quot_d;
  logic [N_BITS-1:0] rem_q,   rem_d;
  logic              dbz_q,   dbz_d;

  logic [N_BITS:0]   trial;
  logic              ge;
  logic [N_BITS-1:0] step_rem;
  logic [N_BITS-1:0] step_work;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  // The difference is below the divisor, so N_BITS-wide modular subtraction
  // yields the exact result.
  always_comb begin
    trial     = {prem_q, work_q[N_BITS-1]};
    ge        = (trial >= {1'b0, dsr_q});
    step_rem  = ge ? (trial[N_BITS-1:0] - dsr_q) : trial[N_BITS-1:0];
    step_work = {work_q[N_BITS-2:0], ge};
  end

  // Control FSM and next-value selection for all datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    work_d  = work_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            prem_d  = '0;
            work_d  = dividend;
            dsr_d   = divisor;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        prem_d = step_rem;
        work_d = step_work;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          quot_d  = step_work;
          rem_d   = step_rem;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      work_q  <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      work_q  <= work_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_divider.sv
// Directed bench for the 4-bit divider. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, away from the active edge.
module tb_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  divider #(.N_BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one division from a falling edge, scramble the operands after the
  // accepting edge, and check latency, busy length and the loaded result.
  task automatic run_div(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                         input int lat, input int eq, input int er, input int ez);
    int c;
    int busy_cnt;
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    c = 0; busy_cnt = 0;
    while (!done && c < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      c++;
    end
    check({tag, " latency"}, c, lat);
    check({tag, " busy_cycles"}, busy_cnt, lat);
    check({tag, " quotient"}, int'(quotient), eq);
    check({tag, " remainder"}, int'(remainder), er);
    check({tag, " div_by_zero"}, int'(div_by_zero), ez);
    $display("txn %s: %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d cycles",
             tag, dd, dv, quotient, remainder, div_by_zero, c);
    @(negedge clk);
    check({tag, " done_single_pulse"}, int'(done), 0);
  endtask

  initial begin
    int c;
    int pulses;
    int first_at;
    int second_at;
    logic [3:0] q1, r1, q2, r2;

    reset = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    #2;
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset div_by_zero", int'(div_by_zero), 0);
    // start while held in reset must have no effect
    start = 1'b1; dividend = 4'd7; divisor = 4'd0;
    @(negedge clk);
    check("reset start_ignored done", int'(done), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // basic and boundary divisions
    run_div("13/4", 4'd13, 4'd4, 4, 3, 1, 0);
    run_div("7/0", 4'd7, 4'd0, 0, 15, 7, 1);
    run_div("0/5", 4'd0, 4'd5, 4, 0, 0, 0);
    run_div("15/15", 4'd15, 4'd15, 4, 1, 0, 0);
    run_div("15/1", 4'd15, 4'd1, 4, 15, 0, 0);
    run_div("5/9", 4'd5, 4'd9, 4, 0, 5, 0);

    // start pulsed and operands changed mid-SHIFT: ignored, one done pulse
    start = 1'b1; dividend = 4'd11; divisor = 4'd3;
    @(posedge clk);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 2) begin
        start = 1'b1; dividend = 4'd2; divisor = 4'd0;
      end else begin
        start = 1'b0; dividend = 4'd9; divisor = 4'd7;
      end
      if (busy) check("ignored_start held quotient", int'(quotient), 0);
      if (done) begin
        pulses++;
        check("ignored_start quotient", int'(quotient), 3);
        check("ignored_start remainder", int'(remainder), 2);
        check("ignored_start div_by_zero", int'(div_by_zero), 0);
      end
    end
    check("ignored_start done_pulses", pulses, 1);
    $display("txn ignored_start: 11/3 -> q=%0d r=%0d pulses=%0d", quotient, remainder, pulses);

    // back-to-back: start held through DONE, 9/2 then 14/3
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3;
    first_at = -1; second_at = -1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (c = 0; c < 15; c++) begin
      if (first_at >= 0 && c == first_at + 1) start = 1'b0;
      if (done) begin
        if (first_at < 0) begin
          first_at = c; q1 = quotient; r1 = remainder;
        end else if (second_at < 0) begin
          second_at = c; q2 = quotient; r2 = remainder;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b first_latency", first_at, 4);
    check("b2b spacing", second_at - first_at, 5);
    check("b2b q1", int'(q1), 4);
    check("b2b r1", int'(r1), 1);
    check("b2b q2", int'(q2), 4);
    check("b2b r2", int'(r2), 2);
    $display("txn b2b: 9/2 -> (%0d,%0d) at %0d, 14/3 -> (%0d,%0d) at %0d",
             q1, r1, first_at, q2, r2, second_at);

    // reset during step 2 aborts the division
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort quotient", int'(quotient), 0);
    check("abort remainder", int'(remainder), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("abort no_activity", pulses, 0);
    $display("txn abort: reset mid-operation, activity=%0d", pulses);

    run_div("6/4", 4'd6, 4'd4, 4, 1, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
